// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, async ROM addressing, IF/ID pipeline register,
// stall/flush/redirect handling, halt/resume and sticky fetch-fault detection.
module fetch_unit #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
    parameter int unsigned                ROM_ADDR_BITS = 12,
    parameter logic [31:0]                NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     pc_src_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_i,
    input  logic                     halt_i,
    input  logic                     resume_i,
    output logic [ADDRESS_WIDTH-1:0] rom_pc_o,
    input  logic [31:0]              rom_instr_i,
    output logic [31:0]              id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] id_pc_o,
    output logic [ADDRESS_WIDTH-1:0] id_pc_plus4_o,
    output logic                     id_valid_o,
    output logic                     fault_o,
    output logic [1:0]               fault_cause_o,
    output logic [31:0]              fetch_count_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_RANGE      = 2'b10;

    // ROM size in bytes, one bit wider than the PC so 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] ROM_BYTES =
        {{ADDRESS_WIDTH{1'b0}}, 1'b1} << ROM_ADDR_BITS;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH:0]   pc_last_byte;
    logic                     target_misaligned;
    logic                     pc_out_of_range;

    assign rom_pc_o          = pc;
    assign pc_plus4          = pc + ADDRESS_WIDTH'(4);
    // A word fetch touches bytes PC..PC+3; the last one must still lie inside the ROM.
    assign pc_last_byte      = {1'b0, pc} + (ADDRESS_WIDTH+1)'(3);
    assign pc_out_of_range   = pc_last_byte >= ROM_BYTES;
    assign target_misaligned = pc_target_i[1:0] != 2'b00;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values;
    // the reset branch is the first test inside the clocked block, which makes it synchronous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_RUN;
            pc            <= RESET_PC;
            id_instr_o    <= NOP_INSTR;
            id_pc_o       <= '0;
            id_pc_plus4_o <= '0;
            id_valid_o    <= 1'b0;
            fault_o       <= 1'b0;
            fault_cause_o <= 2'b00;
            fetch_count_o <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (pc_src_i && target_misaligned) begin
                        state         <= S_FAULT;
                        fault_o       <= 1'b1;
                        fault_cause_o <= CAUSE_MISALIGNED;
                        id_instr_o    <= NOP_INSTR;
                        id_pc_o       <= '0;
                        id_pc_plus4_o <= '0;
                        id_valid_o    <= 1'b0;
                    end else if (pc_src_i) begin
                        // Redirect beats stall; a simultaneous halt takes effect after the PC moves.
                        pc            <= pc_target_i;
                        id_instr_o    <= NOP_INSTR;
                        id_pc_o       <= '0;
                        id_pc_plus4_o <= '0;
                        id_valid_o    <= 1'b0;
                        if (halt_i) begin
                            state <= S_HALTED;
                        end
                    end else if (halt_i) begin
                        state         <= S_HALTED;
                        id_instr_o    <= NOP_INSTR;
                        id_pc_o       <= '0;
                        id_pc_plus4_o <= '0;
                        id_valid_o    <= 1'b0;
                    end else if (stall_i) begin
                        if (flush_i) begin
                            id_instr_o    <= NOP_INSTR;
                            id_pc_o       <= '0;
                            id_pc_plus4_o <= '0;
                            id_valid_o    <= 1'b0;
                        end
                    end else if (pc_out_of_range) begin
                        state         <= S_FAULT;
                        fault_o       <= 1'b1;
                        fault_cause_o <= CAUSE_RANGE;
                        id_instr_o    <= NOP_INSTR;
                        id_pc_o       <= '0;
                        id_pc_plus4_o <= '0;
                        id_valid_o    <= 1'b0;
                    end else begin
                        pc <= pc_plus4;
                        if (flush_i) begin
                            id_instr_o    <= NOP_INSTR;
                            id_pc_o       <= '0;
                            id_pc_plus4_o <= '0;
                            id_valid_o    <= 1'b0;
                        end else begin
                            id_instr_o    <= rom_instr_i;
                            id_pc_o       <= pc;
                            id_pc_plus4_o <= pc_plus4;
                            id_valid_o    <= 1'b1;
                            fetch_count_o <= fetch_count_o + 32'd1;
                        end
                    end
                end

                S_HALTED: begin
                    id_instr_o    <= NOP_INSTR;
                    id_pc_o       <= '0;
                    id_pc_plus4_o <= '0;
                    id_valid_o    <= 1'b0;
                    if (pc_src_i) begin
                        pc <= pc_target_i;
                    end
                    if (resume_i) begin
                        state <= S_RUN;
                    end
                end

                S_FAULT: begin
                    // Sticky: only reset leaves this state.
                    id_instr_o    <= NOP_INSTR;
                    id_pc_o       <= '0;
                    id_pc_plus4_o <= '0;
                    id_valid_o    <= 1'b0;
                end

                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule
